// File: rtl/cmos_capture_pixel.sv
// cmos_capture_pixel: DVP capture front end (settle/arm frame gating, byte packing, pixel x/y); frame_w/frame_h stats built only with CMOS_CAPTURE_STATS_EN
module cmos_capture_pixel #(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int WAIT_FRAME    = 10,
    parameter int CNT_W         = 12
) (
    input  logic                            cam_pclk,
    input  logic                            rst,
    input  logic                            cam_vsync,
    input  logic                            cam_href,
    input  logic [DATA_W-1:0]               cam_data,
    input  logic                            capture_en,
    output logic                            frame_vsync,
    output logic                            frame_href,
    output logic                            frame_clken,
    output logic [DATA_W*BYTES_PER_PIX-1:0] frame_data,
    output logic [CNT_W-1:0]                pix_x,
    output logic [CNT_W-1:0]                pix_y,
    output logic                            frame_done,
    output logic                            line_err,
    output logic [CNT_W-1:0]                frame_w,
    output logic [CNT_W-1:0]                frame_h
);
    localparam int         PIX_W     = DATA_W * BYTES_PER_PIX;
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_PIX - 1);
    localparam logic [3:0] WAIT_CNT  = 4'(WAIT_FRAME);

    typedef enum logic [1:0] {S_SETTLE, S_ARMED, S_ACTIVE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        settle_cnt, settle_cnt_nxt;
    logic              vsync_d0, vsync_d1, href_d0, href_d1;
    logic [DATA_W-1:0] data_d0;
    logic              pos_vsync, neg_href, active, packing, pix_done;
    logic [1:0]        byte_cnt;
    logic [PIX_W-1:0]  word, word_nxt;
    logic [CNT_W-1:0]  x_cnt, y_cnt;

    assign pos_vsync   = vsync_d0 & ~vsync_d1;
    assign neg_href    = ~href_d0 & href_d1;
    assign active      = state == S_ACTIVE;
    assign packing     = active & href_d0;
    assign pix_done    = packing & (byte_cnt == LAST_BYTE);
    assign word_nxt    = PIX_W'({word, data_d0});
    assign frame_vsync = vsync_d1 & active;
    assign frame_href  = href_d1 & active;

    always_ff @(posedge cam_pclk) begin
        if (rst) begin
            vsync_d0 <= 1'b0;
            vsync_d1 <= 1'b0;
            href_d0  <= 1'b0;
            href_d1  <= 1'b0;
            data_d0  <= '0;
        end else begin
            vsync_d0 <= cam_vsync;
            vsync_d1 <= vsync_d0;
            href_d0  <= cam_href;
            href_d1  <= href_d0;
            data_d0  <= cam_data;
        end
    end

    // capture_en only matters on a frame boundary, so frames are never cut
    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        if (pos_vsync) begin
            state_nxt      = state == S_SETTLE ? (settle_cnt == WAIT_CNT ? S_ARMED : S_SETTLE)
                           : capture_en ? S_ACTIVE : S_ARMED;
            settle_cnt_nxt = state == S_SETTLE && settle_cnt != WAIT_CNT ? settle_cnt + 4'd1 : settle_cnt;
        end
    end

    always_ff @(posedge cam_pclk) begin
        if (rst) begin
            state      <= S_SETTLE;
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
        end
    end

    always_ff @(posedge cam_pclk) begin
        if (rst) begin
            byte_cnt    <= '0;
            word        <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            frame_clken <= 1'b0;
            frame_data  <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            line_err    <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            byte_cnt    <= pix_done || !packing ? 2'd0 : byte_cnt + 2'd1;
            word        <= packing ? word_nxt : word;
            frame_clken <= pix_done;
            line_err    <= active & neg_href & (byte_cnt != 2'd0);
            frame_done  <= active & pos_vsync;
            x_cnt       <= pos_vsync || neg_href ? '0 : x_cnt + CNT_W'(pix_done);
            y_cnt       <= pos_vsync ? '0 : y_cnt + CNT_W'(neg_href);
            if (pix_done) begin
                frame_data <= word_nxt;
                pix_x      <= x_cnt;
                pix_y      <= y_cnt;
            end
        end
    end

`ifdef CMOS_CAPTURE_STATS_EN
    logic [CNT_W-1:0] last_w;

    always_ff @(posedge cam_pclk) begin
        if (rst) begin
            last_w  <= '0;
            frame_w <= '0;
            frame_h <= '0;
        end else begin
            last_w <= neg_href ? x_cnt : last_w;
            if (active && pos_vsync) begin
                frame_w <= last_w;
                frame_h <= y_cnt;
            end
        end
    end
`else
    assign frame_w = '0;
    assign frame_h = '0;
`endif

endmodule

// File: tb/tb_cmos_capture_pixel.sv
// tb_cmos_capture_pixel: randomized frames checked against a frame-level reference model
module tb_cmos_capture_pixel;
    localparam int DW  = 8;
    localparam int BPP = 2;
    localparam int WF  = 2;
    localparam int CW  = 12;
    localparam int PW  = DW * BPP;
`ifdef CMOS_CAPTURE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          cam_pclk = 1'b0;
    logic          rst = 1'b1;
    logic          cam_vsync = 1'b0;
    logic          cam_href = 1'b0;
    logic [DW-1:0] cam_data = '0;
    logic          capture_en = 1'b1;
    logic          frame_vsync, frame_href, frame_clken, frame_done, line_err;
    logic [PW-1:0] frame_data;
    logic [CW-1:0] pix_x, pix_y, frame_w, frame_h;

    cmos_capture_pixel #(.DATA_W(DW), .BYTES_PER_PIX(BPP), .WAIT_FRAME(WF), .CNT_W(CW)) dut (
        .cam_pclk(cam_pclk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .capture_en(capture_en), .frame_vsync(frame_vsync),
        .frame_href(frame_href), .frame_clken(frame_clken), .frame_data(frame_data),
        .pix_x(pix_x), .pix_y(pix_y), .frame_done(frame_done), .line_err(line_err),
        .frame_w(frame_w), .frame_h(frame_h)
    );

    always #5 cam_pclk = ~cam_pclk;

    int cyc = 0;
    always @(posedge cam_pclk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [PW-1:0] data; int x; int y; } pix_t;
    typedef struct { int cyc; int w; int h; } fd_t;

    pix_t pq[$];
    int   leq[$];
    fd_t  fdq[$];
    int   n_cmp = 0, n_err = 0;
    int   act_cyc = -1, rst_chk = -1;
    bit   act_val = 0, exp_act = 0, chk_on = 0, exp_b;
    bit   vs1 = 0, vs2 = 0, hr1 = 0, hr2 = 0;
    int   exp_fw = 0, exp_fh = 0;
    int   n_rise = 0, stat_w = 0, stat_h = 0;
    bit   cur_cap = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge cam_pclk);
        #1;
    endtask

    // everything due after the reset edge is forgotten; frame counting restarts
    task automatic apply_reset();
        while (pq.size() > 0 && pq[$].cyc >= cyc + 1) void'(pq.pop_back());
        while (leq.size() > 0 && leq[$] >= cyc + 1) void'(leq.pop_back());
        while (fdq.size() > 0 && fdq[$].cyc >= cyc + 1) void'(fdq.pop_back());
        act_cyc = cyc + 1;
        act_val = 1'b0;
        rst_chk = cyc + 1;
        n_rise  = 0;
        cur_cap = 1'b0;
        stat_w  = 0;
        stat_h  = 0;
    endtask

    task automatic do_frame(input int nlines, input int rst_line, input bit toggle, input bit new_en, input bit directed);
        int            nb, px, rem;
        logic [PW-1:0] word;
        logic [DW-1:0] b;
        logic [DW-1:0] dir_bytes [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        tick();
        cam_vsync = 1'b1;
        n_rise++;
        if (cur_cap) fdq.push_back(fd_t'{cyc + 2, STATS ? stat_w : 0, STATS ? stat_h : 0});
        cur_cap = n_rise >= WF + 2 && capture_en;
        act_cyc = cyc + 2;
        act_val = cur_cap;
        stat_w  = 0;
        stat_h  = 0;
        repeat (2) tick();
        cam_vsync = 1'b0;
        repeat (3) tick();
        for (int l = 0; l < nlines; l++) begin
            nb   = directed && l == 0 ? 4 : int'($urandom_range(9, l == rst_line ? 3 : 1));
            px   = 0;
            rem  = 0;
            word = '0;
            for (int i = 0; i < nb; i++) begin
                tick();
                rst      = 1'b0;
                cam_href = 1'b1;
                b        = directed && l == 0 ? dir_bytes[i] : DW'($urandom);
                cam_data = b;
                if (toggle && l == 0 && i == 0) capture_en = new_en;
                if (l == rst_line && i == 2) begin
                    rst = 1'b1;
                    apply_reset();
                end
                if (cur_cap) begin
                    word = (word << DW) | PW'(b);
                    rem++;
                    if (rem == BPP) begin
                        pq.push_back(pix_t'{cyc + 2, word, px, l});
                        px++;
                        rem = 0;
                    end
                end
            end
            tick();
            rst      = 1'b0;
            cam_href = 1'b0;
            if (cur_cap) begin
                if (rem != 0) leq.push_back(cyc + 2);
                stat_w = px;
                stat_h = l + 1;
            end
            repeat (3) tick();
        end
        repeat (4) tick();
    endtask

    always @(negedge cam_pclk) begin
        if (chk_on) begin
            if (cyc == act_cyc) exp_act = act_val;
            if (cyc == rst_chk) begin
                exp_fw = 0;
                exp_fh = 0;
                check("rst_frame_data", frame_data, 0);
                check("rst_pix_x", pix_x, 0);
                check("rst_pix_y", pix_y, 0);
            end
            check("frame_vsync", frame_vsync, vs2 & exp_act);
            check("frame_href", frame_href, hr2 & exp_act);
            exp_b = pq.size() > 0 && pq[0].cyc == cyc;
            check("frame_clken", frame_clken, exp_b);
            if (exp_b) begin
                check("frame_data", frame_data, pq[0].data);
                check("pix_x", pix_x, pq[0].x);
                check("pix_y", pix_y, pq[0].y);
                void'(pq.pop_front());
            end
            exp_b = leq.size() > 0 && leq[0] == cyc;
            check("line_err", line_err, exp_b);
            if (exp_b) void'(leq.pop_front());
            exp_b = fdq.size() > 0 && fdq[0].cyc == cyc;
            if (exp_b) begin
                exp_fw = fdq[0].w;
                exp_fh = fdq[0].h;
                void'(fdq.pop_front());
            end
            check("frame_done", frame_done, exp_b);
            check("frame_w", frame_w, exp_fw);
            check("frame_h", frame_h, exp_fh);
        end
        vs2 = vs1;
        vs1 = cam_vsync;
        hr2 = hr1;
        hr1 = cam_href;
    end

    initial begin
        bit en_pat [8] = '{0, 0, 1, 1, 0, 1, 0, 1};
        tick();
        chk_on  = 1'b1;
        rst_chk = cyc;
        repeat (2) tick();
        rst = 1'b0;
        for (int f = 0; f < 5; f++) do_frame(int'($urandom_range(4, 1)), -1, 1'b0, 1'b0, f == 3);
        for (int f = 0; f < 8; f++) do_frame(int'($urandom_range(4, 1)), -1, 1'b1, en_pat[f], 1'b0);
        do_frame(3, 1, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 7; f++) do_frame(int'($urandom_range(4, 1)), -1, 1'b0, 1'b0, 1'b0);
        repeat (6) tick();
        check("pixels_left", pq.size(), 0);
        check("line_err_left", leq.size(), 0);
        check("frame_done_left", fdq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
